// File: rtl/if_id_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// if_id_pipe_ctrl
//   IF/ID pipeline register plus the fetch-side hazard controller.
//   - Captures the fetched instruction and its PC into the ID stage each cycle.
//   - Registers the PC controller's flush request (inval_out) and returns it as
//     inval_in, so PC control knows the ID slot currently holds a bubble.
//   - Stalls fetch while a B/BR in ID waits on flags produced in EX, or while a
//     BR waits on its source register (EX writer, or MEM load).
//   - Latches HALT. Only rst leaves the halted state.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   IF_instr, IF_pc          instruction fetched this cycle and its address
//   inval_out                flush request from PC control (taken branch in ID)
//   ex_sets_flags            EX instruction writes Z/V/N at the end of this cycle
//   ex_rd_wr/ex_rd/ex_is_load      EX destination write info
//   mem_rd_wr/mem_rd/mem_is_load   MEM destination write info
//   ID_instr, ID_pc, ID_valid      contents of the ID slot
//   inval_in                 registered flush flag (one cycle per accepted flush)
//   pc_write_en              PC register may update this cycle
//   idex_bubble              ID/EX must load a bubble this cycle
//   stalled, halted          controller state visibility
// -----------------------------------------------------------------------------
module if_id_pipe_ctrl #(
    parameter logic [15:0] NOP_INSTR   = 16'h0000,
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IF_instr,
    input  logic [15:0] IF_pc,
    input  logic        inval_out,
    input  logic        ex_sets_flags,
    input  logic        ex_rd_wr,
    input  logic [3:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        mem_rd_wr,
    input  logic [3:0]  mem_rd,
    input  logic        mem_is_load,
    output logic [15:0] ID_instr,
    output logic [15:0] ID_pc,
    output logic        ID_valid,
    output logic        inval_in,
    output logic        pc_write_en,
    output logic        idex_bubble,
    output logic        stalled,
    output logic        halted
);

    localparam logic [3:0] OP_B  = 4'hC;
    localparam logic [3:0] OP_BR = 4'hD;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] id_instr_r;
    logic [15:0] id_pc_r;
    logic        id_valid_r;
    logic        inval_in_r;

    logic [15:0] id_instr_nxt_s;
    logic [15:0] id_pc_nxt_s;
    logic        id_valid_nxt_s;
    logic        inval_in_nxt_s;

    logic [3:0]  op_s;
    logic [3:0]  rs_s;
    logic        is_b_s;
    logic        is_br_s;
    logic        hazard_s;
    logic        halt_det_s;
    logic        pc_write_en_s;
    logic        idex_bubble_s;

    // Decode the ID slot and evaluate the branch hazard and halt conditions.
    // An invalid (flushed) slot can raise neither.
    always_comb begin
        op_s    = id_instr_r[15:12];
        rs_s    = id_instr_r[7:4];
        is_b_s  = (op_s == OP_B);
        is_br_s = (op_s == OP_BR);
        hazard_s = id_valid_r & (
                       ((is_b_s | is_br_s) & ex_sets_flags)
                     | (is_br_s & ex_rd_wr & (ex_rd == rs_s))
                     | (is_br_s & mem_rd_wr & mem_is_load & (mem_rd == rs_s)));
        // An instruction in a slot just flushed by inval_in must not halt.
        halt_det_s = id_valid_r & (op_s == HALT_OPCODE) & ~inval_in_r;
    end

    // Per-cycle action in priority order: halt, flush, hazard, advance.
    // Outputs are combinational so a stall or halt drops pc_write_en in the
    // very cycle it is detected.
    always_comb begin
        state_nxt_s    = state_r;
        id_instr_nxt_s = id_instr_r;
        id_pc_nxt_s    = id_pc_r;
        id_valid_nxt_s = id_valid_r;
        inval_in_nxt_s = 1'b0;
        pc_write_en_s  = 1'b0;
        idex_bubble_s  = 1'b1;
        if (rst) begin
            // Register update is handled by the reset branch of the flops.
            pc_write_en_s = 1'b0;
            idex_bubble_s = 1'b1;
        end else if ((state_r == ST_HALTED) || halt_det_s) begin
            state_nxt_s   = ST_HALTED;
            pc_write_en_s = 1'b0;
            idex_bubble_s = 1'b1;
        end else if (inval_out && !inval_in_r) begin
            // The taken branch has resolved, so a flush outranks any hazard.
            state_nxt_s    = ST_RUN;
            id_instr_nxt_s = NOP_INSTR;
            id_pc_nxt_s    = IF_pc;
            id_valid_nxt_s = 1'b0;
            inval_in_nxt_s = 1'b1;
            pc_write_en_s  = 1'b1;
            idex_bubble_s  = 1'b0;
        end else if (hazard_s) begin
            state_nxt_s   = ST_STALL;
            pc_write_en_s = 1'b0;
            idex_bubble_s = 1'b1;
        end else begin
            // Normal advance; also covers a repeated inval_out while inval_in=1.
            state_nxt_s    = ST_RUN;
            id_instr_nxt_s = IF_instr;
            id_pc_nxt_s    = IF_pc;
            id_valid_nxt_s = 1'b1;
            pc_write_en_s  = 1'b1;
            idex_bubble_s  = 1'b0;
        end
    end

    // IF/ID register, flush flag and controller state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            id_instr_r <= NOP_INSTR;
            id_pc_r    <= RESET_PC;
            id_valid_r <= 1'b0;
            inval_in_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            id_instr_r <= id_instr_nxt_s;
            id_pc_r    <= id_pc_nxt_s;
            id_valid_r <= id_valid_nxt_s;
            inval_in_r <= inval_in_nxt_s;
        end
    end

    assign ID_instr    = id_instr_r;
    assign ID_pc       = id_pc_r;
    assign ID_valid    = id_valid_r;
    assign inval_in    = inval_in_r;
    assign pc_write_en = pc_write_en_s;
    assign idex_bubble = idex_bubble_s;
    assign stalled     = (state_r == ST_STALL);
    assign halted      = (state_r == ST_HALTED) & ~rst;

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_id_pipe_ctrl
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the IF/ID slot kept in this bench.
// -----------------------------------------------------------------------------
module tb_if_id_pipe_ctrl;

    localparam logic [15:0] NOP = 16'h0000;
    localparam logic [15:0] RPC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] IF_instr, IF_pc;
    logic        inval_out, ex_sets_flags, ex_rd_wr, ex_is_load;
    logic        mem_rd_wr, mem_is_load;
    logic [3:0]  ex_rd, mem_rd;
    logic [15:0] ID_instr, ID_pc;
    logic        ID_valid, inval_in, pc_write_en, idex_bubble, stalled, halted;

    int n_assert = 0;
    int n_fail   = 0;

    // Model of the slot contents and controller mode.
    logic [15:0] m_instr, m_pc;
    bit          m_valid, m_inval, m_stall, m_halt;

    if_id_pipe_ctrl #(.NOP_INSTR(NOP), .RESET_PC(RPC), .HALT_OPCODE(4'hF)) dut (
        .clk(clk), .rst(rst), .IF_instr(IF_instr), .IF_pc(IF_pc),
        .inval_out(inval_out), .ex_sets_flags(ex_sets_flags),
        .ex_rd_wr(ex_rd_wr), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .mem_rd_wr(mem_rd_wr), .mem_rd(mem_rd), .mem_is_load(mem_is_load),
        .ID_instr(ID_instr), .ID_pc(ID_pc), .ID_valid(ID_valid),
        .inval_in(inval_in), .pc_write_en(pc_write_en),
        .idex_bubble(idex_bubble), .stalled(stalled), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Does the instruction currently in ID have to wait this cycle?
    function automatic bit model_waits();
        int op, rs;
        bit flag_wait, reg_wait;
        op = int'(m_instr[15:12]);
        rs = int'(m_instr[7:4]);
        if (!m_valid) return 1'b0;
        flag_wait = (op == 12 || op == 13) && ex_sets_flags;
        reg_wait  = (op == 13) && ((ex_rd_wr && int'(ex_rd) == rs) ||
                                   (mem_rd_wr && mem_is_load && int'(mem_rd) == rs));
        return flag_wait || reg_wait;
    endfunction

    function automatic bit model_halt_seen();
        return m_halt || (m_valid && m_instr[15:12] == 4'hF && !m_inval);
    endfunction

    function automatic bit model_flush_taken();
        return inval_out && !m_inval;
    endfunction

    // PC may move only when nothing freezes the front end this cycle.
    function automatic bit model_pc_moves();
        if (rst || model_halt_seen()) return 1'b0;
        if (model_flush_taken()) return 1'b1;
        return !model_waits();
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        if (rst) begin
            m_instr = NOP; m_pc = RPC; m_valid = 0; m_inval = 0; m_stall = 0; m_halt = 0;
        end else if (model_halt_seen()) begin
            m_halt = 1; m_stall = 0; m_inval = 0;
        end else if (model_flush_taken()) begin
            m_instr = NOP; m_pc = IF_pc; m_valid = 0; m_inval = 1; m_stall = 0;
        end else if (model_waits()) begin
            m_stall = 1; m_inval = 0;
        end else begin
            m_instr = IF_instr; m_pc = IF_pc; m_valid = 1; m_inval = 0; m_stall = 0;
        end
    endtask

    // One clock: check all outputs mid-cycle, then step the model at the edge.
    task automatic cycle();
        bit mv;
        @(negedge clk);
        mv = model_pc_moves();
        chk("ID_instr",    ID_instr,          m_instr);
        chk("ID_pc",       ID_pc,             m_pc);
        chk("ID_valid",    16'(ID_valid),     16'(m_valid));
        chk("inval_in",    16'(inval_in),     16'(m_inval));
        chk("pc_write_en", 16'(pc_write_en),  16'(mv));
        chk("idex_bubble", 16'(idex_bubble),  16'(!mv));
        chk("stalled",     16'(stalled),      16'(m_stall));
        chk("halted",      16'(halted),       16'(m_halt && !rst));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        rst = 0; inval_out = 0; ex_sets_flags = 0; ex_rd_wr = 0; ex_rd = 4'h0;
        ex_is_load = 0; mem_rd_wr = 0; mem_rd = 4'h0; mem_is_load = 0;
    endtask

    task automatic fetch(input logic [15:0] instr, input logic [15:0] pc);
        IF_instr = instr; IF_pc = pc;
    endtask

    initial begin
        quiet();
        rst = 1; fetch(16'h0000, 16'h0000);
        m_instr = NOP; m_pc = RPC; m_valid = 0; m_inval = 0; m_stall = 0; m_halt = 0;
        @(posedge clk); #1;
        cycle();
        chk("reset_valid", 16'(ID_valid), 16'h0000);
        chk("reset_pc", ID_pc, RPC);

        // 1. straight-line fetch
        quiet(); fetch(16'h1123, 16'h0000); cycle();
        chk("t1_instr0", ID_instr, 16'h1123);
        fetch(16'h2456, 16'h0002); cycle();
        chk("t1_instr1", ID_instr, 16'h2456);
        chk("t1_pc1", ID_pc, 16'h0002);

        // 2. B waiting on flags: one stall cycle
        fetch(16'hC004, 16'h0004); cycle();
        fetch(16'h3000, 16'h0006); ex_sets_flags = 1; cycle();
        chk("t2_stalled", 16'(stalled), 16'h0001);
        chk("t2_held", ID_instr, 16'hC004);
        ex_sets_flags = 0; cycle();
        chk("t2_resume", ID_instr, 16'h3000);

        // 3. BR rs=3 behind an LW rd=3: EX then MEM stall
        fetch(16'hD030, 16'h0008); cycle();
        fetch(16'h4000, 16'h000A);
        ex_rd_wr = 1; ex_rd = 4'h3; ex_is_load = 1; cycle();
        chk("t3_stall_ex", 16'(stalled), 16'h0001);
        ex_rd_wr = 0; ex_is_load = 0; mem_rd_wr = 1; mem_rd = 4'h3; mem_is_load = 1; cycle();
        chk("t3_stall_mem", ID_instr, 16'hD030);
        quiet(); cycle();
        chk("t3_resume", ID_instr, 16'h4000);

        // 4. flush pulse, then a repeated pulse that must be ignored
        fetch(16'h1111, 16'h000C); inval_out = 1; cycle();
        chk("t4_valid", 16'(ID_valid), 16'h0000);
        chk("t4_nop", ID_instr, NOP);
        chk("t4_inval", 16'(inval_in), 16'h0001);
        fetch(16'h2222, 16'h000E); cycle();
        chk("t4_inval_drop", 16'(inval_in), 16'h0000);
        chk("t4_advance", ID_instr, 16'h2222);
        inval_out = 0;

        // 5. HALT latches and freezes everything
        fetch(16'hF000, 16'h0010); cycle();
        fetch(16'h5555, 16'h0012); cycle();
        chk("t5_halted", 16'(halted), 16'h0001);
        for (int i = 0; i < 4; i++) begin
            inval_out = 1'(i); fetch(16'h6000 + 16'(i), 16'h0014); cycle();
        end
        chk("t5_frozen", ID_instr, 16'hF000);

        // 6a. reset out of HALTED
        quiet(); rst = 1; cycle();
        chk("t6_halt_rst", 16'(halted), 16'h0000);
        chk("t6_halt_pc", ID_pc, RPC);
        // 6b. reset in the middle of a stall
        quiet(); fetch(16'hC004, 16'h0020); cycle();
        ex_sets_flags = 1; cycle();
        chk("t6_in_stall", 16'(stalled), 16'h0001);
        rst = 1; cycle();
        chk("t6_stall_rst", 16'(stalled), 16'h0000);
        chk("t6_stall_valid", 16'(ID_valid), 16'h0000);

        // Randomized traffic, biased towards branches and register matches.
        for (int i = 0; i < 1500; i++) begin
            int sel;
            logic [15:0] w;
            sel = int'($urandom_range(0, 15));
            w = 16'($urandom);
            if (sel < 4)       w[15:12] = 4'hC;
            else if (sel < 9)  w[15:12] = 4'hD;
            else if (sel == 9) w[15:12] = 4'hF;
            w[7:4] = 4'($urandom_range(0, 3));
            fetch(w, 16'($urandom));
            rst           = ($urandom_range(0, 24) == 0);
            inval_out     = ($urandom_range(0, 5) == 0);
            ex_sets_flags = ($urandom_range(0, 3) == 0);
            ex_rd_wr      = 1'($urandom);
            ex_rd         = 4'($urandom_range(0, 3));
            ex_is_load    = 1'($urandom);
            mem_rd_wr     = 1'($urandom);
            mem_rd        = 4'($urandom_range(0, 3));
            mem_is_load   = 1'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
